// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the memory arbiter slice.
//   ramstate_t   : RAM status encoding reported by the memory model.
//   arb_state_t  : grant FSM states of mem_arbiter.
//   STARVE_W     : width of the icache starvation counter.
//   starve_hit() : starvation threshold test used by the grant FSM.
// -----------------------------------------------------------------------------
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } arb_state_t;

    localparam int unsigned STARVE_W = 8;
    localparam logic [STARVE_W-1:0] STARVE_SAT = 8'hFF;

    // True when a starvation count (plus an optional pending increment) has
    // reached the limit. Done in 32 bits so the +1 cannot wrap at 255.
    function automatic logic starve_hit(input logic [STARVE_W-1:0] cnt,
                                        input logic                plus_one,
                                        input int unsigned         limit);
        logic [31:0] w_sum;
        w_sum = {{(32-STARVE_W){1'b0}}, cnt} + {31'd0, plus_one};
        return (w_sum >= limit);
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// -----------------------------------------------------------------------------
// arb_starve_ctr
// 8-bit saturating counter of dcache beats granted while icache waits.
// Ports:
//   CLK   in   clock
//   nRST  in   asynchronous active-low reset
//   inc   in   count one starved beat (ignored once saturated)
//   clr   in   clear the count; wins over inc
//   cnt   out  current count
// -----------------------------------------------------------------------------
module arb_starve_ctr
    import cpu_types_pkg::*;
(
    input  logic                CLK,
    input  logic                nRST,
    input  logic                inc,
    input  logic                clr,
    output logic [STARVE_W-1:0] cnt
);

    logic [STARVE_W-1:0] r_cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != STARVE_SAT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates a single-port RAM between an icache and a dcache. The dcache has
// priority, and a granted dcache burst is held across two-word pairs. Icache
// starvation is bounded by DSTARVE_MAX dcache beats.
// Optional statistics counters are built when MEM_ARB_STATS_EN is defined;
// otherwise dbeats/ibeats/cont_cycles are tied to 0.
// Ports:
//   CLK, nRST                    clock, asynchronous active-low reset
//   iREN, iaddr / iload, iwait   icache request / response
//   dREN, dWEN, daddr, dstore    dcache request
//   dload, dwait                 dcache response
//   ramREN, ramWEN, ramaddr,
//   ramstore / ramload, ramstate RAM strobes, address, data, status
//   ram_err                      sticky RAM error flag
//   dbeats, ibeats, cont_cycles  statistics
// -----------------------------------------------------------------------------
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned DSTARVE_MAX = 8
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        ram_err,
    output logic [31:0] dbeats,
    output logic [31:0] ibeats,
    output logic [31:0] cont_cycles
);

    arb_state_t          r_state;
    arb_state_t          w_next_state;
    ramstate_t           w_ramstate;
    logic                w_access;
    logic                w_dreq;
    logic                w_dbeat;
    logic                w_ibeat;
    logic                r_parity;
    logic                r_ram_err;
    logic [STARVE_W-1:0] w_starve_cnt;
    logic                w_starve_inc;
    logic                w_starve_clr;

    assign w_ramstate = ramstate_t'(ramstate);
    assign w_access   = (w_ramstate == ACCESS);
    assign w_dreq     = dREN | dWEN;
    assign w_dbeat    = (r_state == DGRANT) && w_access;
    assign w_ibeat    = (r_state == IGRANT) && w_access;

    // Next-state decode. In DGRANT, r_parity==1 means the beat completing now
    // closes a two-word pair, the only point where icache may preempt.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (iREN && starve_hit(w_starve_cnt, 1'b0, DSTARVE_MAX)) begin
                    w_next_state = IGRANT;
                end else if (w_dreq) begin
                    w_next_state = DGRANT;
                end else if (iREN) begin
                    w_next_state = IGRANT;
                end else begin
                    w_next_state = IDLE;
                end
            end
            DGRANT: begin
                if (!w_dreq) begin
                    w_next_state = IDLE;
                end else if (w_dbeat && r_parity && iREN &&
                             starve_hit(w_starve_cnt, 1'b1, DSTARVE_MAX)) begin
                    w_next_state = IGRANT;
                end else begin
                    w_next_state = DGRANT;
                end
            end
            IGRANT: begin
                if (w_ibeat || !iREN) begin
                    if (w_dreq) begin
                        w_next_state = DGRANT;
                    end else if (iREN) begin
                        w_next_state = IGRANT;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Grant FSM plus the state that follows it (pair parity, sticky error).
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state   <= IDLE;
            r_parity  <= 1'b0;
            r_ram_err <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == DGRANT) && (w_next_state != DGRANT)) begin
                r_parity <= 1'b0;
            end else if (w_dbeat) begin
                r_parity <= ~r_parity;
            end
            // Only an error seen during a granted access is recorded.
            if ((w_ramstate == ERROR) && (r_state != IDLE)) begin
                r_ram_err <= 1'b1;
            end
        end
    end

    assign ram_err = r_ram_err;

    // Count dcache beats that keep a pending icache request waiting; the count
    // restarts whenever icache actually gets the bus.
    assign w_starve_inc = w_dbeat && iREN;
    assign w_starve_clr = (w_next_state == IGRANT) && (r_state != IGRANT);

    arb_starve_ctr u_starve (
        .CLK  (CLK),
        .nRST (nRST),
        .inc  (w_starve_inc),
        .clr  (w_starve_clr),
        .cnt  (w_starve_cnt)
    );

    // Datapath mux. Outputs depend only on registered state and live inputs,
    // so an asynchronous reset drops every strobe at once.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iload    = '0;
        dload    = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        unique case (r_state)
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                dload    = ramload;
                dwait    = ~w_access;
            end
            IGRANT: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                iload   = ramload;
                iwait   = ~w_access;
            end
            default: begin
            end
        endcase
    end

`ifdef MEM_ARB_STATS_EN
    logic [31:0] r_dbeats;
    logic [31:0] r_ibeats;
    logic [31:0] r_cont_cycles;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_dbeats      <= '0;
            r_ibeats      <= '0;
            r_cont_cycles <= '0;
        end else begin
            if (w_dbeat) begin
                r_dbeats <= r_dbeats + 32'd1;
            end
            if (w_ibeat) begin
                r_ibeats <= r_ibeats + 32'd1;
            end
            if (w_dreq && iREN) begin
                r_cont_cycles <= r_cont_cycles + 32'd1;
            end
        end
    end

    assign dbeats      = r_dbeats;
    assign ibeats      = r_ibeats;
    assign cont_cycles = r_cont_cycles;
`else
    assign dbeats      = '0;
    assign ibeats      = '0;
    assign cont_cycles = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter. u_dut uses the default DSTARVE_MAX=8,
// u_dut2 uses DSTARVE_MAX=2; both share the same stimulus. Inputs change 1ns
// after the rising edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    logic [31:0] iload,  iload2;
    logic        iwait,  iwait2;
    logic [31:0] dload,  dload2;
    logic        dwait,  dwait2;
    logic        ramREN, ramREN2;
    logic        ramWEN, ramWEN2;
    logic [31:0] ramaddr, ramaddr2;
    logic [31:0] ramstore, ramstore2;
    logic        ram_err, ram_err2;
    logic [31:0] dbeats, dbeats2;
    logic [31:0] ibeats, ibeats2;
    logic [31:0] cont_cycles, cont_cycles2;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    mem_arbiter #(.DSTARVE_MAX(8)) u_dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .ram_err(ram_err),
        .dbeats(dbeats), .ibeats(ibeats), .cont_cycles(cont_cycles)
    );

    mem_arbiter #(.DSTARVE_MAX(2)) u_dut2 (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload2), .iwait(iwait2),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload2), .dwait(dwait2),
        .ramREN(ramREN2), .ramWEN(ramWEN2), .ramaddr(ramaddr2), .ramstore(ramstore2),
        .ramload(ramload), .ramstate(ramstate), .ram_err(ram_err2),
        .dbeats(dbeats2), .ibeats(ibeats2), .cont_cycles(cont_cycles2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic go();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    task automatic clear_inputs();
        iREN = 0; iaddr = 0; dREN = 0; dWEN = 0; daddr = 0; dstore = 0;
        ramload = 0; ramstate = RS_FREE;
    endtask

    task automatic do_reset();
        nRST = 0;
        clear_inputs();
        go();
        nRST = 1;
    endtask

    task automatic test_reset();
        nRST = 0;
        iREN = 1; iaddr = 32'h44; dREN = 1; daddr = 32'h100; dstore = 32'h5;
        ramload = 32'h1234; ramstate = RS_ACCESS;
        go(); go(); smp();
        checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL rst_ramREN got %h want 0", ramREN); end
        checks++; if (ramWEN !== 1'b0) begin errors++; $display("FAIL rst_ramWEN got %h want 0", ramWEN); end
        checks++; if (ramaddr !== 32'h0) begin errors++; $display("FAIL rst_ramaddr got %h want 0", ramaddr); end
        checks++; if (ramstore !== 32'h0) begin errors++; $display("FAIL rst_ramstore got %h want 0", ramstore); end
        checks++; if (dload !== 32'h0 || iload !== 32'h0) begin errors++; $display("FAIL rst_loads got %h/%h want 0/0", dload, iload); end
        checks++; if (iwait !== 1'b1 || dwait !== 1'b1) begin errors++; $display("FAIL rst_waits got %b/%b want 1/1", iwait, dwait); end
        checks++; if (ram_err !== 1'b0) begin errors++; $display("FAIL rst_ram_err got %b want 0", ram_err); end
        checks++; if (dbeats !== 0 || ibeats !== 0 || cont_cycles !== 0) begin errors++; $display("FAIL rst_stats got %0d/%0d/%0d want 0/0/0", dbeats, ibeats, cont_cycles); end
        clear_inputs();
        go();
        nRST = 1;
        go();
    endtask

    task automatic test_dcache_read();
        dREN = 1; daddr = 32'h100; ramload = 32'hDEADBEEF; ramstate = RS_BUSY;
        smp();
        checks++; if (ramREN !== 1'b0 || dwait !== 1'b1) begin errors++; $display("FAIL dread_idle got ramREN=%b dwait=%b want 0/1", ramREN, dwait); end
        go();
        ramstate = RS_ACCESS;
        smp();
        checks++; if (ramREN !== 1'b1 || ramWEN !== 1'b0) begin errors++; $display("FAIL dread_strobe got %b/%b want 1/0", ramREN, ramWEN); end
        checks++; if (ramaddr !== 32'h100) begin errors++; $display("FAIL dread_addr got %h want 100", ramaddr); end
        checks++; if (dload !== 32'hDEADBEEF) begin errors++; $display("FAIL dread_dload got %h want deadbeef", dload); end
        checks++; if (dwait !== 1'b0 || iwait !== 1'b1) begin errors++; $display("FAIL dread_waits got d=%b i=%b want 0/1", dwait, iwait); end
        checks++; if (iload !== 32'h0) begin errors++; $display("FAIL dread_iload got %h want 0", iload); end
        go();
        clear_inputs();
        smp();
        checks++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin errors++; $display("FAIL dread_drop got ramREN=%b iwait=%b want 0/1", ramREN, iwait); end
        go();
        smp();
        checks++; if (ramaddr !== 32'h0 || dwait !== 1'b1) begin errors++; $display("FAIL dread_back_idle got addr=%h dwait=%b want 0/1", ramaddr, dwait); end
`ifdef MEM_ARB_STATS_EN
        checks++; if (dbeats !== 32'd1) begin errors++; $display("FAIL dread_dbeats got %0d want 1", dbeats); end
`endif
        go();
    endtask

    task automatic test_burst_lock();
        do_reset();
        iREN = 1; iaddr = 32'h300;
        dWEN = 1; dREN = 1; daddr = 32'h200; dstore = 32'hA;
        ramstate = RS_ACCESS; ramload = 32'h77;
        smp();
        checks++; if (ramaddr !== 32'h0) begin errors++; $display("FAIL burst_idle_addr got %h want 0", ramaddr); end
        go();
        smp();
        checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin errors++; $display("FAIL burst_wen_prio got WEN=%b REN=%b want 1/0", ramWEN, ramREN); end
        checks++; if (ramaddr !== 32'h200 || ramstore !== 32'hA) begin errors++; $display("FAIL burst_beat1 got %h/%h want 200/a", ramaddr, ramstore); end
        checks++; if (iwait !== 1'b1 || iload !== 32'h0) begin errors++; $display("FAIL burst_i_blocked got iwait=%b iload=%h want 1/0", iwait, iload); end
        go();
        daddr = 32'h204; dstore = 32'hB;
        smp();
        checks++; if (ramaddr !== 32'h204 || ramWEN !== 1'b1 || ramstore !== 32'hB) begin errors++; $display("FAIL burst_beat2 got %h/%b/%h want 204/1/b", ramaddr, ramWEN, ramstore); end
        go();
        dWEN = 0; dREN = 0; ramstate = RS_FREE;
        smp();
        checks++; if (ramaddr === 32'h300 || ramWEN !== 1'b0) begin errors++; $display("FAIL burst_locked got addr=%h WEN=%b want !=300/0", ramaddr, ramWEN); end
        go();
        smp();
        checks++; if (ramaddr !== 32'h0 || ramREN !== 1'b0) begin errors++; $display("FAIL burst_idle2 got %h/%b want 0/0", ramaddr, ramREN); end
        checks++; if (u_dut.w_starve_cnt !== 8'd2) begin errors++; $display("FAIL burst_starve_cnt got %0d want 2", u_dut.w_starve_cnt); end
        go();
        ramstate = RS_ACCESS; ramload = 32'h55;
        smp();
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h300 || ramWEN !== 1'b0) begin errors++; $display("FAIL burst_igrant got REN=%b addr=%h WEN=%b want 1/300/0", ramREN, ramaddr, ramWEN); end
        checks++; if (iload !== 32'h55 || iwait !== 1'b0 || dwait !== 1'b1) begin errors++; $display("FAIL burst_iresp got %h/%b/%b want 55/0/1", iload, iwait, dwait); end
        checks++; if (u_dut.w_starve_cnt !== 8'd0) begin errors++; $display("FAIL burst_starve_clr got %0d want 0", u_dut.w_starve_cnt); end
        go();
        iREN = 0; ramstate = RS_FREE;
        go();
        smp();
        checks++; if (ramaddr !== 32'h0 || ramREN !== 1'b0) begin errors++; $display("FAIL burst_end_idle got %h/%b want 0/0", ramaddr, ramREN); end
        go();
    endtask

    task automatic test_starvation();
        do_reset();
        dREN = 1; iREN = 1; daddr = 32'h400; iaddr = 32'h500;
        ramstate = RS_ACCESS; ramload = 32'h99;
        smp();
        go();
        smp();
        checks++; if (ramaddr2 !== 32'h400 || dwait2 !== 1'b0) begin errors++; $display("FAIL starve_beat1 got %h/%b want 400/0", ramaddr2, dwait2); end
        go();
        smp();
        checks++; if (ramaddr2 !== 32'h400 || u_dut2.w_starve_cnt !== 8'd1) begin errors++; $display("FAIL starve_beat2 got %h cnt=%0d want 400/1", ramaddr2, u_dut2.w_starve_cnt); end
        go();
        smp();
        checks++; if (ramaddr2 !== 32'h500 || iwait2 !== 1'b0 || dwait2 !== 1'b1) begin errors++; $display("FAIL starve_igrant got %h/%b/%b want 500/0/1", ramaddr2, iwait2, dwait2); end
        checks++; if (u_dut2.w_starve_cnt !== 8'd0) begin errors++; $display("FAIL starve_cnt_clr got %0d want 0", u_dut2.w_starve_cnt); end
        checks++; if (ramaddr !== 32'h400) begin errors++; $display("FAIL starve_max8_holds got %h want 400", ramaddr); end
        go();
        clear_inputs();
        go(); go();
    endtask

    task automatic test_simultaneous();
        do_reset();
        iREN = 1; dREN = 1; daddr = 32'h600; iaddr = 32'h700;
        ramstate = RS_ACCESS; ramload = 32'h11;
        go();
        smp();
        checks++; if (ramaddr !== 32'h600 || dload !== 32'h11 || dwait !== 1'b0) begin errors++; $display("FAIL simul_dfirst got %h/%h/%b want 600/11/0", ramaddr, dload, dwait); end
        checks++; if (iwait !== 1'b1 || iload !== 32'h0) begin errors++; $display("FAIL simul_iwait got %b/%h want 1/0", iwait, iload); end
        go();
        dREN = 0; ramstate = RS_FREE;
        go();
        smp();
        checks++; if (ramaddr !== 32'h0 || ramREN !== 1'b0) begin errors++; $display("FAIL simul_idle got %h/%b want 0/0", ramaddr, ramREN); end
        go();
        ramstate = RS_ACCESS;
        smp();
        checks++; if (ramaddr !== 32'h700 || ramREN !== 1'b1 || iload !== 32'h11 || iwait !== 1'b0) begin errors++; $display("FAIL simul_igrant got %h/%b/%h/%b want 700/1/11/0", ramaddr, ramREN, iload, iwait); end
        go();
        iREN = 0; ramstate = RS_FREE;
        go();
        smp();
        checks++; if (ramREN !== 1'b0 || ramaddr !== 32'h0 || iwait !== 1'b1) begin errors++; $display("FAIL simul_end got %b/%h/%b want 0/0/1", ramREN, ramaddr, iwait); end
`ifdef MEM_ARB_STATS_EN
        checks++; if (dbeats !== 32'd1 || ibeats !== 32'd1 || cont_cycles !== 32'd2) begin errors++; $display("FAIL simul_stats got %0d/%0d/%0d want 1/1/2", dbeats, ibeats, cont_cycles); end
`endif
        go();
    endtask

    task automatic test_error();
        do_reset();
        dREN = 1; daddr = 32'h800; ramstate = RS_BUSY;
        go();
        ramstate = RS_ERROR;
        smp();
        checks++; if (dwait !== 1'b1) begin errors++; $display("FAIL err_dwait1 got %b want 1", dwait); end
        for (int i = 0; i < 2; i++) begin
            go();
            smp();
            checks++; if (dwait !== 1'b1 || ram_err !== 1'b1) begin errors++; $display("FAIL err_hold%0d got dwait=%b err=%b want 1/1", i, dwait, ram_err); end
        end
        go();
        ramstate = RS_ACCESS; ramload = 32'h3C;
        smp();
        checks++; if (dwait !== 1'b0 || dload !== 32'h3C || ram_err !== 1'b1) begin errors++; $display("FAIL err_recover got %b/%h/%b want 0/3c/1", dwait, dload, ram_err); end
        go();
        clear_inputs();
        go(); go();
        smp();
        checks++; if (ram_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", ram_err); end
        go();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        dWEN = 1; daddr = 32'h900; dstore = 32'h1; ramstate = RS_ACCESS;
        go();
        smp();
        checks++; if (ramWEN !== 1'b1 || ramaddr !== 32'h900) begin errors++; $display("FAIL midrst_beat1 got %b/%h want 1/900", ramWEN, ramaddr); end
        go();
`ifdef MEM_ARB_STATS_EN
        checks++; if (dbeats !== 32'd1) begin errors++; $display("FAIL midrst_pre_dbeats got %0d want 1", dbeats); end
`endif
        #2;
        nRST = 0;
        #1;
        checks++; if (ramWEN !== 1'b0 || ramREN !== 1'b0 || ramaddr !== 32'h0) begin errors++; $display("FAIL midrst_abort got %b/%b/%h want 0/0/0", ramWEN, ramREN, ramaddr); end
        checks++; if (dwait !== 1'b1 || dbeats !== 32'd0) begin errors++; $display("FAIL midrst_state got dwait=%b dbeats=%0d want 1/0", dwait, dbeats); end
        go();
        smp();
        checks++; if (ramWEN !== 1'b0 || ramREN !== 1'b0) begin errors++; $display("FAIL midrst_held got %b/%b want 0/0", ramWEN, ramREN); end
        clear_inputs();
        go();
        nRST = 1;
        go();
    endtask

    initial begin
        clear_inputs();
        nRST = 0;
        test_reset();
        test_dcache_read();
        test_burst_lock();
        test_starvation();
        test_simultaneous();
        test_error();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
